// File: rtl/dds_pkg.sv
// Purpose: shared DDS constants, control-word type, FSM state type and ms-to-cycle helper.
// Latency: none (declarations only).
// Backpressure: none.
package dds_pkg;

    localparam int CLK_HZ       = 50_000_000;
    localparam int DDS_KW_WIDTH = 12;
    localparam int DDS_KW_MIN   = 1;
    localparam int DDS_KW_MAX   = 4095;

    // Control word as seen by the wave/phase-accumulator stage
    typedef logic [DDS_KW_WIDTH-1:0] kw_t;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_REPEAT_WAIT = 2'd1,
        ST_REPEATING   = 2'd2,
        ST_BOTH_LOCK   = 2'd3
    } kw_state_e;

    // Milliseconds to CLK cycles at CLK_HZ
    function automatic int ms_to_cyc(input int ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Purpose: synchronise one raw active-low key, debounce it, emit a press pulse and held level.
// Latency: 2 sync cycles + DEBOUNCE_CYC cycles from a clean raw edge to key_press/key_held.
// Backpressure: none; key_press is a single-cycle pulse that must be consumed when it fires.
module key_debounce
    import dds_pkg::*;
#(
    parameter int DEBOUNCE_CYC = ms_to_cyc(20)
) (
    input  logic CLK,
    input  logic Rstn,
    input  logic key_raw,
    output logic key_press,
    output logic key_held
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic          key_sync1;
    logic          key_sync2;
    logic          key_level;
    logic [CW-1:0] stable_cnt;

    // Two-flop synchroniser; comes out of reset reading "released"
    always_ff @(posedge CLK or negedge Rstn) begin
        if (!Rstn) begin
            key_sync1 <= 1'b1;
            key_sync2 <= 1'b1;
        end else begin
            key_sync1 <= key_raw;
            key_sync2 <= key_sync1;
        end
    end

    // Accept a new level only after it has differed from the accepted one for DEBOUNCE_CYC cycles
    always_ff @(posedge CLK or negedge Rstn) begin
        if (!Rstn) begin
            key_level  <= 1'b1;
            stable_cnt <= '0;
            key_press  <= 1'b0;
        end else begin
            key_press <= 1'b0;
            if (key_sync2 != key_level) begin
                if (stable_cnt == CW'(DEBOUNCE_CYC - 1)) begin
                    key_level  <= key_sync2;
                    stable_cnt <= '0;
                    key_press  <= ~key_sync2;
                end else begin
                    stable_cnt <= stable_cnt + CW'(1);
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

    assign key_held = ~key_level;

endmodule

// File: rtl/key_freq_word_ctrl.sv
// Purpose: turn add/sub push-buttons into a saturating DDS frequency word with auto-repeat.
// Latency: accepted press -> KW on next edge; clean raw edge -> KW in 2 + DEBOUNCE_CYC + 1 cycles.
// Backpressure: none; KW is always valid and KW_Change strobes once per actual value change.
module key_freq_word_ctrl
    import dds_pkg::*;
#(
    parameter int KW_WIDTH       = DDS_KW_WIDTH,
    parameter int KW_RESET       = 1,
    parameter int KW_MIN         = DDS_KW_MIN,
    parameter int KW_MAX         = DDS_KW_MAX,
    parameter int KW_STEP        = 1,
    parameter int DEBOUNCE_CYC   = ms_to_cyc(20),
    parameter int REPEAT_DLY_CYC = ms_to_cyc(500),
    parameter int REPEAT_PER_CYC = ms_to_cyc(100)
) (
    input  logic                CLK,
    input  logic                Rstn,
    input  logic                KW_Add_In,
    input  logic                KW_Sub_In,
    output logic [KW_WIDTH-1:0] KW,
    output logic                KW_Change
);

    localparam int EW   = KW_WIDTH + 1;
    localparam int TMAX = (REPEAT_DLY_CYC > REPEAT_PER_CYC) ? REPEAT_DLY_CYC : REPEAT_PER_CYC;
    localparam int TW   = $clog2(TMAX + 1);

    kw_state_e             state;
    logic                  active_sub;
    logic [TW-1:0]         rpt_timer;
    logic                  add_press;
    logic                  add_held;
    logic                  sub_press;
    logic                  sub_held;
    logic                  active_held;
    logic                  step_sub;
    logic [EW-1:0]         kw_ext;
    logic [EW-1:0]         kw_up;
    logic [KW_WIDTH-1:0]   kw_stepped;
    logic                  kw_differs;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_add_key (
        .CLK       (CLK),
        .Rstn      (Rstn),
        .key_raw   (KW_Add_In),
        .key_press (add_press),
        .key_held  (add_held)
    );

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_sub_key (
        .CLK       (CLK),
        .Rstn      (Rstn),
        .key_raw   (KW_Sub_In),
        .key_press (sub_press),
        .key_held  (sub_held)
    );

    // Saturating one-step value; direction comes from the fresh press in IDLE, else the latched key
    always_comb begin
        step_sub    = (state == ST_IDLE) ? sub_press : active_sub;
        active_held = active_sub ? sub_held : add_held;
        kw_ext      = {1'b0, KW};
        kw_up       = kw_ext + EW'(KW_STEP);
        kw_stepped  = KW;
        if (step_sub) begin
            if (kw_ext < EW'(KW_MIN + KW_STEP)) begin
                kw_stepped = KW_WIDTH'(KW_MIN);
            end else begin
                kw_stepped = KW_WIDTH'(kw_ext - EW'(KW_STEP));
            end
        end else begin
            if (kw_up > EW'(KW_MAX)) begin
                kw_stepped = KW_WIDTH'(KW_MAX);
            end else begin
                kw_stepped = kw_up[KW_WIDTH-1:0];
            end
        end
        kw_differs = (kw_stepped != KW);
    end

    // Press/hold/repeat FSM with a shared countdown timer; both keys held always forces the lock
    always_ff @(posedge CLK or negedge Rstn) begin
        if (!Rstn) begin
            state      <= ST_IDLE;
            KW         <= KW_WIDTH'(KW_RESET);
            KW_Change  <= 1'b0;
            rpt_timer  <= '0;
            active_sub <= 1'b0;
        end else begin
            KW_Change <= 1'b0;
            if (add_held && sub_held) begin
                state <= ST_BOTH_LOCK;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (add_press ^ sub_press) begin
                            active_sub <= sub_press;
                            KW         <= kw_stepped;
                            KW_Change  <= kw_differs;
                            rpt_timer  <= TW'(REPEAT_DLY_CYC - 1);
                            state      <= ST_REPEAT_WAIT;
                        end
                    end
                    ST_REPEAT_WAIT, ST_REPEATING: begin
                        if (!active_held) begin
                            state <= ST_IDLE;
                        end else if (rpt_timer == '0) begin
                            KW        <= kw_stepped;
                            KW_Change <= kw_differs;
                            rpt_timer <= TW'(REPEAT_PER_CYC - 1);
                            state     <= ST_REPEATING;
                        end else begin
                            rpt_timer <= rpt_timer - TW'(1);
                        end
                    end
                    ST_BOTH_LOCK: begin
                        if (!add_held && !sub_held) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_freq_word_ctrl.sv
// Purpose: directed scenarios plus random key activity against a timestamp-based reference model.
// Latency: model outputs are compared every cycle; directed checks sample #1 after the edge.
// Backpressure: not applicable.
module tb_key_freq_word_ctrl;

    localparam int DEB    = 8;
    localparam int DLY    = 40;
    localparam int PER    = 10;
    localparam int KMIN   = 1;
    localparam int KMAX   = 4095;
    localparam int KSTEP  = 1;
    localparam int KRESET = 1;

    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_REP  = 2;
    localparam int M_LOCK = 3;

    logic        CLK;
    logic        Rstn;
    logic        KW_Add_In;
    logic        KW_Sub_In;
    logic [11:0] KW;
    logic        KW_Change;

    int n_checks = 0;
    int n_fail   = 0;
    int strobes  = 0;

    // Reference model state: per key [0]=add, [1]=sub
    int     m_s1[2];
    int     m_s2[2];
    int     m_acc[2];
    int     m_run[2];
    int     m_press[2];
    int     m_held[2];
    int     m_kw;
    int     m_chg;
    int     m_state;
    int     m_active;
    longint m_cyc;
    longint m_deadline;

    key_freq_word_ctrl #(
        .DEBOUNCE_CYC   (DEB),
        .REPEAT_DLY_CYC (DLY),
        .REPEAT_PER_CYC (PER)
    ) dut (
        .CLK       (CLK),
        .Rstn      (Rstn),
        .KW_Add_In (KW_Add_In),
        .KW_Sub_In (KW_Sub_In),
        .KW        (KW),
        .KW_Change (KW_Change)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int step_kw(input int kw, input int is_sub);
        if (is_sub != 0) return (kw < KMIN + KSTEP) ? KMIN : kw - KSTEP;
        return (kw + KSTEP > KMAX) ? KMAX : kw + KSTEP;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_s1[k] = 1; m_s2[k] = 1; m_acc[k] = 1;
            m_run[k] = 0; m_press[k] = 0; m_held[k] = 0;
        end
        m_kw = KRESET; m_chg = 0; m_state = M_IDLE; m_active = 0;
        m_cyc = 0; m_deadline = 0;
    endtask

    task automatic model_do_step(input int is_sub);
        int old;
        old   = m_kw;
        m_kw  = step_kw(m_kw, is_sub);
        m_chg = (m_kw != old) ? 1 : 0;
    endtask

    // One rising edge of the reference: decisions use what the key filters showed before the edge
    task automatic model_edge();
        int raw[2];
        if (!Rstn) begin
            model_reset();
            return;
        end
        raw[0] = int'(KW_Add_In);
        raw[1] = int'(KW_Sub_In);
        m_cyc++;
        m_chg = 0;
        if (m_held[0] != 0 && m_held[1] != 0) begin
            m_state = M_LOCK;
        end else begin
            case (m_state)
                M_IDLE: if (m_press[0] != m_press[1]) begin
                    m_active   = (m_press[1] != 0) ? 1 : 0;
                    model_do_step(m_active);
                    m_deadline = m_cyc + DLY;
                    m_state    = M_WAIT;
                end
                M_WAIT, M_REP: if (m_held[m_active] == 0) begin
                    m_state = M_IDLE;
                end else if (m_cyc == m_deadline) begin
                    model_do_step(m_active);
                    m_deadline = m_cyc + PER;
                    m_state    = M_REP;
                end
                default: if (m_held[0] == 0 && m_held[1] == 0) m_state = M_IDLE;
            endcase
        end
        // A key level is accepted after DEB consecutive edges of disagreement
        for (int k = 0; k < 2; k++) begin
            m_press[k] = 0;
            if (m_s2[k] != m_acc[k]) begin
                m_run[k]++;
                if (m_run[k] == DEB) begin
                    m_acc[k]   = m_s2[k];
                    m_run[k]   = 0;
                    m_press[k] = (m_acc[k] == 0) ? 1 : 0;
                end
            end else begin
                m_run[k] = 0;
            end
            m_held[k] = (m_acc[k] == 0) ? 1 : 0;
            m_s2[k]   = m_s1[k];
            m_s1[k]   = raw[k];
        end
    endtask

    // Advance one clock: compare on the falling edge, step the model on the rising edge
    task automatic cyc();
        @(negedge CLK);
        check_val("kw", int'(KW), m_kw);
        check_val("kw_change", int'(KW_Change), m_chg);
        if (KW_Change === 1'b1) strobes++;
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic wait_strobe(input int limit, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (KW_Change !== 1'b1 && n < limit);
    endtask

    task automatic wait_kw(input int target, input int limit, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (int'(KW) != target && n < limit);
    endtask

    task automatic do_reset();
        KW_Add_In = 1'b1;
        KW_Sub_In = 1'b1;
        Rstn      = 1'b0;
        model_reset();
        #1;
        check_val("rst_kw", int'(KW), KRESET);
        check_val("rst_chg", int'(KW_Change), 0);
        cyc();
        cyc();
        Rstn = 1'b1;
        repeat (5) cyc();
    endtask

    initial begin
        int n;
        int s0;
        Rstn      = 1'b1;
        KW_Add_In = 1'b1;
        KW_Sub_In = 1'b1;
        model_reset();
        #2;

        // 1: clean add press, exact raw-edge-to-KW latency
        do_reset();
        s0 = strobes;
        KW_Add_In = 1'b0;
        wait_strobe(50, n);
        check_val("t1_latency", n, 2 + DEB + 1);
        check_val("t1_kw", int'(KW), 2);
        repeat (20 - n) cyc();
        KW_Add_In = 1'b1;
        repeat (20) cyc();
        check_val("t1_strobes", strobes - s0, 1);

        // 2: bouncy press, only the final stable level counts
        do_reset();
        s0 = strobes;
        for (int i = 0; i < 4; i++) begin
            KW_Add_In = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (3) cyc();
        end
        KW_Add_In = 1'b0;
        repeat (30) cyc();
        KW_Add_In = 1'b1;
        repeat (20) cyc();
        check_val("t2_kw", int'(KW), 2);
        check_val("t2_strobes", strobes - s0, 1);

        // 3: climb to 100, then hold sub so the debounced release lands between repeats 3 and 4
        do_reset();
        KW_Add_In = 1'b0;
        wait_kw(99, 2000, n);
        KW_Add_In = 1'b1;
        repeat (30) cyc();
        check_val("t3_start", int'(KW), 100);
        s0 = strobes;
        KW_Sub_In = 1'b0;
        wait_strobe(50, n);
        repeat (55) cyc();
        KW_Sub_In = 1'b1;
        repeat (30) cyc();
        check_val("t3_kw", int'(KW), 96);
        check_val("t3_strobes", strobes - s0, 4);

        // 4: upper saturation from 4094, then lower saturation at 1
        do_reset();
        KW_Add_In = 1'b0;
        wait_kw(4093, 45000, n);
        KW_Add_In = 1'b1;
        repeat (30) cyc();
        check_val("t4_start", int'(KW), 4094);
        s0 = strobes;
        KW_Add_In = 1'b0;
        repeat (2 + DEB + 1 + DLY + 5 * PER) cyc();
        KW_Add_In = 1'b1;
        repeat (20) cyc();
        check_val("t4_kw_max", int'(KW), KMAX);
        check_val("t4_max_strobes", strobes - s0, 1);
        do_reset();
        s0 = strobes;
        KW_Sub_In = 1'b0;
        repeat (2 + DEB + 1 + DLY + 5 * PER) cyc();
        KW_Sub_In = 1'b1;
        repeat (20) cyc();
        check_val("t4_kw_min", int'(KW), KMIN);
        check_val("t4_min_strobes", strobes - s0, 0);

        // 5: both-held lock, release of one key only, then a fresh press
        do_reset();
        KW_Add_In = 1'b0;
        wait_strobe(50, n);
        repeat (5) cyc();
        KW_Sub_In = 1'b0;
        repeat (100) cyc();
        check_val("t5_lock_kw", int'(KW), 2);
        KW_Sub_In = 1'b1;
        repeat (60) cyc();
        check_val("t5_half_kw", int'(KW), 2);
        KW_Add_In = 1'b1;
        repeat (20) cyc();
        KW_Add_In = 1'b0;
        repeat (20) cyc();
        KW_Add_In = 1'b1;
        repeat (20) cyc();
        check_val("t5_kw", int'(KW), 3);

        // 6: reset while repeating with the key still held
        do_reset();
        KW_Add_In = 1'b0;
        wait_strobe(50, n);
        repeat (45) cyc();
        check_val("t6_pre_kw", int'(KW), 3);
        Rstn = 1'b0;
        model_reset();
        #1;
        check_val("t6_rst_kw", int'(KW), KRESET);
        check_val("t6_rst_chg", int'(KW_Change), 0);
        cyc();
        cyc();
        Rstn = 1'b1;
        wait_strobe(50, n);
        check_val("t6_relatency", n, 2 + DEB + 1);
        check_val("t6_kw", int'(KW), 2);
        wait_strobe(100, n);
        check_val("t6_repeat_dly", n, DLY);
        check_val("t6_kw_rep", int'(KW), 3);
        KW_Add_In = 1'b1;
        repeat (20) cyc();

        // Random key activity with occasional resets, compared cycle by cycle
        do_reset();
        for (int s = 0; s < 60; s++) begin
            int len;
            if ($urandom_range(0, 11) == 0) begin
                Rstn = 1'b0;
                model_reset();
                cyc();
                Rstn = 1'b1;
            end else begin
                KW_Add_In = 1'($urandom_range(0, 1));
                KW_Sub_In = 1'($urandom_range(0, 1));
                len = int'($urandom_range(1, 90));
                repeat (len) cyc();
            end
        end
        KW_Add_In = 1'b1;
        KW_Sub_In = 1'b1;
        repeat (30) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
